// File: rtl/q_episode_ctrl.sv
// rtl/q_episode_ctrl.sv - Q-learning episode sequencer for a 6x6 grid world.
// Optional epsilon-greedy exploration is enabled by defining EPSILON_EXPLORE_EN.
module q_episode_ctrl #(
    parameter int START_STATE = 0,
    parameter int GOAL_STATE  = 35,
    parameter int MAX_STEPS   = 64,
    parameter int EPSILON     = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        q_rd_en,
    output logic [7:0]  q_rd_addr,
    input  logic [31:0] q_rd_data,
    output logic        upd_req,
    input  logic        upd_ack,
    output logic [5:0]  upd_state,
    output logic [1:0]  upd_action,
    output logic [31:0] upd_max_q,
    output logic [3:0]  upd_reward,
    output logic [5:0]  cur_state,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  step_cnt,
    output logic [15:0] episode_cnt
);

    localparam logic [5:0] START_S = 6'(START_STATE);
    localparam logic [5:0] GOAL_S  = 6'(GOAL_STATE);
    localparam logic [7:0] MAX_S   = 8'(MAX_STEPS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_CUR,
        DECIDE,
        FETCH_NXT,
        UPDATE,
        ADVANCE
    } state_t;

    state_t      state;
    logic [2:0]  rd_cnt;
    logic [31:0] best_q;
    logic [1:0]  best_a;
    logic [1:0]  act;
    logic [5:0]  nxt_state;

    logic [1:0]  cap_a;
    logic        cap_better;
    logic [31:0] run_q;
    logic [1:0]  run_a;
    logic [1:0]  sel_act;
    logic [5:0]  sel_nxt;

    // Off-grid moves leave the agent where it is.
    function automatic logic [5:0] next_of(input logic [5:0] s, input logic [1:0] a);
        logic [2:0] col;
        col = 3'(s % 6'd6);
        next_of = s;
        case (a)
            2'd0: if (s >= 6'd6)   next_of = s - 6'd6;
            2'd1: if (col != 3'd5) next_of = s + 6'd1;
            2'd2: if (s < 6'd30)   next_of = s + 6'd6;
            default: if (col != 3'd0) next_of = s - 6'd1;
        endcase
    endfunction

    // Running argmax over the capture window; strict '>' keeps the lowest index on ties.
    assign cap_a      = rd_cnt[1:0] - 2'd1;
    assign cap_better = (rd_cnt == 3'd1) || (q_rd_data > best_q);
    assign run_q      = cap_better ? q_rd_data : best_q;
    assign run_a      = cap_better ? cap_a : best_a;

`ifdef EPSILON_EXPLORE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign sel_act = ({1'b0, lfsr[7:0]} < 9'(EPSILON)) ? lfsr[9:8] : best_a;
`else
    assign sel_act = best_a;
`endif

    assign sel_nxt = next_of(cur_state, sel_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_cnt      <= 3'd0;
            best_q      <= 32'd0;
            best_a      <= 2'd0;
            act         <= 2'd0;
            nxt_state   <= 6'd0;
            q_rd_en     <= 1'b0;
            q_rd_addr   <= 8'd0;
            upd_req     <= 1'b0;
            upd_state   <= 6'd0;
            upd_action  <= 2'd0;
            upd_max_q   <= 32'd0;
            upd_reward  <= 4'd0;
            cur_state   <= START_S;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            step_cnt    <= 8'd0;
            episode_cnt <= 16'd0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_state <= START_S;
                        step_cnt  <= 8'd0;
                        if (START_S == GOAL_S) begin
                            done        <= 1'b1;
                            episode_cnt <= episode_cnt + 16'd1;
                        end else begin
                            state     <= FETCH_CUR;
                            busy      <= 1'b1;
                            q_rd_en   <= 1'b1;
                            q_rd_addr <= {START_S, 2'd0};
                            rd_cnt    <= 3'd0;
                        end
                    end
                end
                FETCH_CUR, FETCH_NXT: begin
                    rd_cnt          <= rd_cnt + 3'd1;
                    q_rd_en         <= (rd_cnt < 3'd3);
                    q_rd_addr[1:0]  <= rd_cnt[1:0] + 2'd1;
                    if (rd_cnt != 3'd0) begin
                        best_q <= run_q;
                        best_a <= run_a;
                    end
                    if (rd_cnt == 3'd4) begin
                        if (state == FETCH_CUR) begin
                            state <= DECIDE;
                        end else begin
                            state      <= UPDATE;
                            upd_req    <= 1'b1;
                            upd_state  <= cur_state;
                            upd_action <= act;
                            upd_max_q  <= run_q;
                            upd_reward <= (nxt_state == GOAL_S) ? 4'd10 : 4'd0;
                        end
                    end
                end
                DECIDE: begin
                    act       <= sel_act;
                    nxt_state <= sel_nxt;
                    state     <= FETCH_NXT;
                    q_rd_en   <= 1'b1;
                    q_rd_addr <= {sel_nxt, 2'd0};
                    rd_cnt    <= 3'd0;
                end
                UPDATE: begin
                    if (upd_ack) begin
                        upd_req <= 1'b0;
                        state   <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    cur_state <= nxt_state;
                    step_cnt  <= step_cnt + 8'd1;
                    if (nxt_state == GOAL_S) begin
                        done        <= 1'b1;
                        episode_cnt <= episode_cnt + 16'd1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if ((step_cnt + 8'd1) >= MAX_S) begin
                        done        <= 1'b1;
                        timeout     <= 1'b1;
                        episode_cnt <= episode_cnt + 16'd1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state     <= FETCH_CUR;
                        q_rd_en   <= 1'b1;
                        q_rd_addr <= {nxt_state, 2'd0};
                        rd_cnt    <= 3'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_episode_ctrl.sv
// tb/tb_q_episode_ctrl.sv - self-checking bench for q_episode_ctrl against a grid-walk model.
module tb_q_episode_ctrl;

    localparam int START = 0;
    localparam int GOAL  = 35;
    localparam int MAXS  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        q_rd_en;
    logic [7:0]  q_rd_addr;
    logic [31:0] q_rd_data = 32'd0;
    logic        upd_req;
    logic        upd_ack = 1'b0;
    logic [5:0]  upd_state;
    logic [1:0]  upd_action;
    logic [31:0] upd_max_q;
    logic [3:0]  upd_reward;
    logic [5:0]  cur_state;
    logic        busy, done, timeout;
    logic [7:0]  step_cnt;
    logic [15:0] episode_cnt;

    logic        g_start;
    logic        g_q_rd_en;
    logic [7:0]  g_q_rd_addr;
    logic [31:0] g_q_rd_data;
    logic        g_upd_req;
    logic        g_upd_ack;
    logic [5:0]  g_upd_state;
    logic [1:0]  g_upd_action;
    logic [31:0] g_upd_max_q;
    logic [3:0]  g_upd_reward;
    logic [5:0]  g_cur_state;
    logic        g_busy, g_done, g_timeout;
    logic [7:0]  g_step_cnt;
    logic [15:0] g_episode_cnt;

    logic [31:0] qmem [256];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          ack_delay = 0;
    bit          spurious = 1'b0;
    int          exp_ep = 0;
    bit          g_rd_seen = 1'b0;

    always #5 clk = ~clk;

    q_episode_ctrl #(.START_STATE(START), .GOAL_STATE(GOAL), .MAX_STEPS(MAXS), .EPSILON(26)) dut (
        .clk(clk), .rst(rst), .start(start),
        .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
        .upd_req(upd_req), .upd_ack(upd_ack), .upd_state(upd_state), .upd_action(upd_action),
        .upd_max_q(upd_max_q), .upd_reward(upd_reward), .cur_state(cur_state),
        .busy(busy), .done(done), .timeout(timeout), .step_cnt(step_cnt), .episode_cnt(episode_cnt)
    );

    q_episode_ctrl #(.START_STATE(35), .GOAL_STATE(35), .MAX_STEPS(MAXS), .EPSILON(26)) dut_g (
        .clk(clk), .rst(rst), .start(g_start),
        .q_rd_en(g_q_rd_en), .q_rd_addr(g_q_rd_addr), .q_rd_data(g_q_rd_data),
        .upd_req(g_upd_req), .upd_ack(g_upd_ack), .upd_state(g_upd_state), .upd_action(g_upd_action),
        .upd_max_q(g_upd_max_q), .upd_reward(g_upd_reward), .cur_state(g_cur_state),
        .busy(g_busy), .done(g_done), .timeout(g_timeout), .step_cnt(g_step_cnt),
        .episode_cnt(g_episode_cnt)
    );

    assign g_q_rd_data = 32'd0;
    assign g_upd_ack   = 1'b0;

    // Q-table memory: data is only meaningful the cycle after a strobe.
    always @(posedge clk) begin
        if (q_rd_en) q_rd_data <= qmem[q_rd_addr];
        else         q_rd_data <= $urandom;
    end

    always @(negedge clk) begin
        if (g_q_rd_en) g_rd_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ack responder plus handshake monitor: payload and agent state must hold while upd_req is high.
    int          req_len = 0;
    logic [43:0] pay_ref;
    logic [5:0]  st_ref;
    always @(negedge clk) begin
        if (upd_req) begin
            req_len++;
            if (req_len == 1) begin
                pay_ref = {upd_state, upd_action, upd_max_q, upd_reward};
                st_ref  = cur_state;
            end else begin
                check("payload_stable", 64'({upd_state, upd_action, upd_max_q, upd_reward}), 64'(pay_ref));
                check("no_advance_before_ack", 64'(cur_state), 64'(st_ref));
            end
            upd_ack = (req_len == ack_delay + 1);
        end else begin
            if (req_len != 0 && !rst) check("req_high_cycles", 64'(req_len), 64'(ack_delay + 1));
            req_len = 0;
            upd_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    function automatic int argmax(int s);
        int b = 0;
        for (int a = 1; a < 4; a++) if (qmem[s*4+a] > qmem[s*4+b]) b = a;
        return b;
    endfunction

    function automatic int mv(int s, int a);
        int r = s / 6;
        int c = s % 6;
        case (a)
            0:       return (r > 0) ? s - 6 : s;
            1:       return (c < 5) ? s + 1 : s;
            2:       return (r < 5) ? s + 6 : s;
            default: return (c > 0) ? s - 1 : s;
        endcase
    endfunction

    function automatic logic [31:0] maxq(int s);
        logic [31:0] m = qmem[s*4];
        for (int a = 1; a < 4; a++) if (qmem[s*4+a] > m) m = qmem[s*4+a];
        return m;
    endfunction

    task automatic run_episode(input int ack_d, input bit poke_start);
        int s = START;
        int n = START;
        int a;
        int steps = 0;
        bit fin = 1'b0;
        bit prev = 1'b0;
        ack_delay = ack_d;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
            if (upd_req && !prev) begin
                a = argmax(s);
                n = mv(s, a);
                check("upd_state", 64'(upd_state), 64'(s));
                check("upd_action", 64'(upd_action), 64'(a));
                check("upd_max_q", 64'(upd_max_q), 64'(maxq(n)));
                check("upd_reward", 64'(upd_reward), (n == GOAL) ? 64'd10 : 64'd0);
                check("busy_mid", 64'(busy), 64'd1);
                steps++;
                s = n;
            end
            prev = upd_req;
            if (done) begin
                fin = 1'b1;
                exp_ep++;
                check("timeout", 64'(timeout), (n != GOAL && steps == MAXS) ? 64'd1 : 64'd0);
                check("step_cnt", 64'(step_cnt), 64'(steps));
                check("cur_state_end", 64'(cur_state), 64'(s));
                check("episode_cnt", 64'(episode_cnt), 64'(exp_ep));
                check("busy_end", 64'(busy), 64'd0);
            end else begin
                start = poke_start && busy && ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!fin) check("episode_done_seen", 64'd0, 64'd1);
        @(negedge clk);
        check("done_pulse_width", 64'(done), 64'd0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        start = 1'b0;
        g_start = 1'b0;
        for (int i = 0; i < 256; i++) qmem[i] = 32'd0;
        repeat (3) @(negedge clk);

        check("rst_q_rd_en", 64'(q_rd_en), 64'd0);
        check("rst_upd_req", 64'(upd_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_step_cnt", 64'(step_cnt), 64'd0);
        check("rst_episode_cnt", 64'(episode_cnt), 64'd0);
        check("rst_cur_state", 64'(cur_state), 64'(START));
        check("rst_payload", 64'({upd_state, upd_action, upd_max_q, upd_reward}), 64'd0);
        check("rst_g_cur_state", 64'(g_cur_state), 64'd35);
        rst = 1'b0;

        // All-zero table: action 0 forever at state 0, ends on the step limit.
        run_episode(0, 1'b0);

        // Start already at the goal.
        @(negedge clk); g_start = 1'b1;
        @(negedge clk); g_start = 1'b0;
        check("goal_start_done", 64'(g_done), 64'd1);
        check("goal_start_step_cnt", 64'(g_step_cnt), 64'd0);
        check("goal_start_timeout", 64'(g_timeout), 64'd0);
        @(negedge clk);
        check("goal_start_done_pulse", 64'(g_done), 64'd0);
        check("goal_start_no_update", 64'(g_upd_req), 64'd0);

        // Directed path east along row 0 then south to the goal via state 29; state 0 has a 1/3 tie.
        for (int i = 0; i < 256; i++) qmem[i] = 32'd0;
        for (int s = 0; s < 5; s++) qmem[s*4+1] = 32'd100;
        qmem[0*4+3] = 32'd100;
        for (int s = 5; s < 35; s += 6) qmem[s*4+2] = 32'd100;
        qmem[29*4+2] = 32'hF000_0000;
        qmem[29*4+0] = 32'h8000_0000;
        run_episode(0, 1'b1);
        run_episode(7, 1'b0);

        // Reset while the next-state fetch is in flight.
        for (int i = 0; i < 256; i++) qmem[i] = $urandom;
        cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 100 && cnt < 5; cyc++) begin
            if (q_rd_en) cnt++;
            if (cnt < 5) @(negedge clk);
        end
        check("reach_fetch_nxt", 64'(cnt), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_upd_req", 64'(upd_req), 64'd0);
        check("midrst_q_rd_en", 64'(q_rd_en), 64'd0);
        check("midrst_cur_state", 64'(cur_state), 64'(START));
        check("midrst_episode_cnt", 64'(episode_cnt), 64'd0);
        rst = 1'b0;
        exp_ep = 0;
        run_episode(1, 1'b0);

        // Random tables, wide values and small values that force ties.
        spurious = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 256; i++)
                qmem[i] = (k % 2 == 0) ? $urandom : 32'($urandom_range(0, 3));
            run_episode($urandom_range(0, 3), 1'b1);
        end
        spurious = 1'b0;

        check("goal_start_never_read", 64'(g_rd_seen), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/q_episode_ctrl.md
Q_EPISODE_CTRL -- requirements
Module: q_episode_ctrl

Interface
REQ-001 The block SHALL have parameters, one per line:
- START_STATE, 0: episode start state (0..35).
- GOAL_STATE, 35: terminal state.
- MAX_STEPS, 64: step limit per episode.
- EPSILON, 26: explore threshold out of 256.
REQ-002 The block SHALL have ports, one per line:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins an episode when idle.
- q_rd_en  out  1  Q-table read strobe.
- q_rd_addr  out  8  {state[5:0], action[1:0]}.
- q_rd_data  in  32  Q value; valid exactly 1 cycle after q_rd_en.
- upd_req  out  1  update request to the Q-update module.
- upd_ack  in  1  update accepted.
- upd_state  out  6  state being updated.
- upd_action  out  2  action being updated.
- upd_max_q  out  32  max Q of next state.
- upd_reward  out  4  reward.
- cur_state  out  6  agent state.
- busy  out  1  episode in progress.
- done  out  1  1-cycle episode-end pulse.
- timeout  out  1  1-cycle pulse with done when the step limit is hit.
- step_cnt  out  8  steps taken this episode.
- episode_cnt  out  16  completed episodes, wraps at 16'hFFFF to 0.

Function
REQ-003 The FSM SHALL have states IDLE, FETCH_CUR, DECIDE, FETCH_NXT, UPDATE and ADVANCE.
REQ-004 In IDLE, start SHALL load cur_state=START_STATE and step_cnt=0, set busy, and go to FETCH_CUR; start outside IDLE SHALL be ignored.
REQ-005 If START_STATE==GOAL_STATE, start SHALL give done one cycle later with step_cnt=0, with no reads and no update.
REQ-006 Each FETCH phase SHALL assert q_rd_en on 4 consecutive cycles for actions 0,1,2,3, capture q_rd_data on the following 4 cycles, and last 5 cycles total.
REQ-007 The argmax SHALL compare Q values as unsigned 32-bit; on a tie the lowest action index SHALL win.
REQ-008 DECIDE (1 cycle) SHALL latch the greedy action of cur_state.
REQ-009 The next state SHALL be: action 0 gives s-6, 1 gives s+1, 2 gives s+6, 3 gives s-1. A move off the 6x6 grid (row 0 north, row 5 south, column 0 west, column 5 east) SHALL leave the state unchanged.
REQ-010 FETCH_NXT SHALL read all 4 Q values of the next state; upd_max_q SHALL be their unsigned maximum.
REQ-011 upd_reward SHALL be 10 when next_state==GOAL_STATE, otherwise 0.
REQ-012 In UPDATE, upd_req SHALL be held high with all upd_* payload stable until the cycle upd_ack is sampled high, then deassert the next cycle. upd_ack while upd_req is low SHALL be ignored.
REQ-013 ADVANCE SHALL set cur_state=next_state and step_cnt+=1. Then:
- if next_state==GOAL_STATE: done pulse, episode_cnt+=1, go to IDLE.
- else if step_cnt reaches MAX_STEPS: done and timeout pulse, episode_cnt+=1, go to IDLE.
- else: go to FETCH_CUR.
REQ-014 If the goal and the step limit occur in the same step, the goal SHALL take priority and timeout SHALL stay 0.
REQ-015 busy SHALL be high in every state except IDLE.

Reset
REQ-016 rst SHALL force IDLE, mid-episode included, and zero every output except cur_state=START_STATE.
REQ-017 rst SHALL drop upd_req immediately and discard any partially captured Q values.

Configuration
REQ-018 With EPSILON_EXPLORE_EN defined, the block SHALL contain a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) that advances every cycle.
REQ-019 With EPSILON_EXPLORE_EN defined, DECIDE SHALL use action=lfsr[9:8] when lfsr[7:0]<EPSILON, otherwise the greedy action.
REQ-020 Without EPSILON_EXPLORE_EN, the block SHALL contain no LFSR and action selection SHALL be purely greedy.

Verification
REQ-021 The bench SHALL cover:
- All Q=0, start, EPSILON_EXPLORE_EN off -> action 0 every step, state stays 0, done+timeout after 64 steps, episode_cnt=1.
- State 29, Q[29][2] largest, ack immediate -> upd_state=29, upd_action=2, next=35, upd_reward=10, done, timeout=0.
- upd_ack delayed 7 cycles -> upd_req high with stable payload for 8 cycles; no state change before ack.
- Q[s][1]==Q[s][3] maximal -> action 1 chosen.
- rst asserted during FETCH_NXT -> next cycle IDLE, busy=0, upd_req=0, cur_state=START_STATE; a new start runs normally.
- START_STATE=35 -> done 1 cycle after start, step_cnt=0, q_rd_en never asserted.
